// File: rtl/data_sram_resp.sv
// data_sram_resp: CPU data SRAM responder, local byte-writable RAM + MMIO.
// Define DATA_SRAM_TIMER_EN to build the free-running timer at offset 0x08.
module data_sram_resp #(
  parameter int          RAM_AW  = 12,
  parameter logic [15:0] MMIO_HI = 16'hbfaf
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic [15:0] led,
  input  logic [7:0]  switch,
  output logic        err_flag
);

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  be
  );
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) res[8*i +: 8] = nw[8*i +: 8];
    return res;
  endfunction

  logic [31:0] mem [2**RAM_AW];
  logic [RAM_AW-1:0] ram_idx;
  logic [13:0] off;
  logic is_mmio, rd, wr;
  logic sel_led, sel_sw, sel_tmr, sel_scr, sel_err;
  logic mapped, err_set, err_clr;
  logic [31:0] scratch, timer, mmio_rdata;
  logic [7:0] sw_s1, sw_s2;
  logic unused_bits;

  assign unused_bits = ^sram_addr[1:0];

  assign ram_idx = sram_addr[RAM_AW+1:2];
  assign off     = sram_addr[15:2];
  assign is_mmio = sram_addr[31:16] == MMIO_HI;
  assign rd      = sram_en && sram_wen == 4'h0;
  assign wr      = sram_en && sram_wen != 4'h0;

  assign sel_led = is_mmio && off == 14'h0;
  assign sel_sw  = is_mmio && off == 14'h1;
  assign sel_scr = is_mmio && off == 14'h3;
  assign sel_err = is_mmio && off == 14'h4;

  assign mapped  = sel_led | sel_sw | sel_tmr | sel_scr | sel_err;
  assign err_set = sram_en && is_mmio && !mapped;
  assign err_clr = wr && sel_err && sram_wen[0] && sram_wdata[0];

`ifdef DATA_SRAM_TIMER_EN
  assign sel_tmr = is_mmio && off == 14'h2;

  // A write to the timer replaces that cycle's increment.
  always_ff @(posedge clk) begin
    if (reset)
      timer <= '0;
    else if (wr && sel_tmr)
      timer <= merge(timer, sram_wdata, sram_wen);
    else
      timer <= timer + 32'd1;
  end
`else
  assign sel_tmr = 1'b0;
  assign timer   = '0;
`endif

  always_comb begin
    mmio_rdata = '0;
    unique case (1'b1)
      sel_led: mmio_rdata = {16'h0, led};
      sel_sw:  mmio_rdata = {24'h0, sw_s2};
      sel_tmr: mmio_rdata = timer;
      sel_scr: mmio_rdata = scratch;
      sel_err: mmio_rdata = {31'h0, err_flag};
      default: mmio_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && wr && !is_mmio)
      for (int i = 0; i < 4; i++)
        if (sram_wen[i])
          mem[ram_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sram_rdata <= '0;
      led        <= '0;
      scratch    <= '0;
      err_flag   <= 1'b0;
      sw_s1      <= '0;
      sw_s2      <= '0;
    end else begin
      sw_s1 <= switch;
      sw_s2 <= sw_s1;
      if (rd)
        sram_rdata <= is_mmio ? mmio_rdata : mem[ram_idx];
      if (wr && sel_led) begin
        if (sram_wen[0]) led[7:0]  <= sram_wdata[7:0];
        if (sram_wen[1]) led[15:8] <= sram_wdata[15:8];
      end
      if (wr && sel_scr)
        scratch <= merge(scratch, sram_wdata, sram_wen);
      // A new error outranks a clear in the same cycle.
      if (err_set)
        err_flag <= 1'b1;
      else if (err_clr)
        err_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// tb_data_sram_resp: vector table, corner sequences and a random run
// checked against a behavioural model of the responder.
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        reset, sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic [15:0] led;
  logic [7:0]  switch;
  logic        err_flag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_sram_resp dut (
    .clk(clk), .reset(reset), .sram_en(sram_en),
    .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .led(led), .switch(switch), .err_flag(err_flag)
  );

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] led;
    logic        err;
  } vec_t;

  vec_t vt[$];

  // behavioural model state
  logic [31:0] m_ram [16];
  logic [31:0] m_rdata, m_scr, m_tmr;
  logic [15:0] m_led;
  logic        m_err;
  logic [7:0]  m_swq[$];

  function automatic logic [31:0] bmerge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk3(input string nm, input logic [31:0] r,
                      input logic [15:0] l, input logic e);
    chk({nm, ".rdata"}, sram_rdata, r);
    chk({nm, ".led"}, {16'h0, led}, {16'h0, l});
    chk({nm, ".err"}, {31'h0, err_flag}, {31'h0, e});
  endtask

  task automatic apply(input logic rst, input logic en,
                       input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [7:0] sw);
    reset      = rst;
    sram_en    = en;
    sram_wen   = wen;
    sram_addr  = addr;
    sram_wdata = wdata;
    switch     = sw;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input logic rst, input logic en,
                            input logic [3:0] wen,
                            input logic [31:0] addr,
                            input logic [31:0] wdata,
                            input logic [7:0] sw);
    logic mmio, ok;
    logic [15:0] off;
    logic [31:0] t;
    if (rst) begin
      m_rdata = '0; m_led = '0; m_scr = '0;
      m_err = 1'b0; m_tmr = '0;
      m_swq = '{8'h0, 8'h0};
      return;
    end
    mmio = addr[31:16] == 16'hbfaf;
    off  = {addr[15:2], 2'b00};
    ok   = off == 16'h0 || off == 16'h4 ||
           off == 16'hc || off == 16'h10;
`ifdef DATA_SRAM_TIMER_EN
    ok = ok || off == 16'h8;
`endif
    if (en && wen == 4'h0) begin
      if (!mmio) m_rdata = m_ram[addr[5:2]];
      else if (!ok) m_rdata = '0;
      else case (off)
        16'h0:   m_rdata = {16'h0, m_led};
        16'h4:   m_rdata = {24'h0, m_swq[1]};
        16'h8:   m_rdata = m_tmr;
        16'hc:   m_rdata = m_scr;
        default: m_rdata = {31'h0, m_err};
      endcase
    end
    if (en && wen != 0 && mmio && off == 16'h8 && ok)
      m_tmr = bmerge(m_tmr, wdata, wen);
    else
      m_tmr = m_tmr + 1;
    if (en && wen != 4'h0) begin
      if (!mmio)
        m_ram[addr[5:2]] = bmerge(m_ram[addr[5:2]], wdata, wen);
      else if (off == 16'h0) begin
        t = bmerge({16'h0, m_led}, wdata, wen & 4'b0011);
        m_led = t[15:0];
      end else if (off == 16'hc)
        m_scr = bmerge(m_scr, wdata, wen);
      else if (off == 16'h10 && wen[0] && wdata[0])
        m_err = 1'b0;
    end
    if (en && mmio && !ok) m_err = 1'b1;
    m_swq.push_front(sw);
    if (m_swq.size() > 2) void'(m_swq.pop_back());
  endtask

  initial begin
    logic rst, en;
    logic [3:0] wen;
    logic [31:0] addr, wdata;
    logic [7:0] sw;
    logic [15:0] off;

    vt.push_back('{1, 4'hF, 32'h00000040, 32'h11223344,
                   32'h0, 16'h0, 0});
    vt.push_back('{1, 4'h2, 32'h00000040, 32'h0000AA00,
                   32'h0, 16'h0, 0});
    vt.push_back('{1, 4'h0, 32'h00000040, 32'h0,
                   32'h1122AA44, 16'h0, 0});
    vt.push_back('{1, 4'hF, 32'hbfaf0000, 32'hFFFF1234,
                   32'h1122AA44, 16'h1234, 0});
    vt.push_back('{1, 4'h0, 32'hbfaf0000, 32'h0,
                   32'h00001234, 16'h1234, 0});
    vt.push_back('{1, 4'h0, 32'hbfaf0020, 32'h0,
                   32'h0, 16'h1234, 1});
    vt.push_back('{1, 4'h1, 32'hbfaf0010, 32'h1,
                   32'h0, 16'h1234, 0});
    vt.push_back('{1, 4'hF, 32'hbfaf0004, 32'hFFFFFFFF,
                   32'h0, 16'h1234, 0});
    vt.push_back('{1, 4'h2, 32'hbfaf0000, 32'h0000AB00,
                   32'h0, 16'hAB34, 0});
    vt.push_back('{1, 4'hF, 32'hbfaf000C, 32'hDEADBEEF,
                   32'h0, 16'hAB34, 0});
    vt.push_back('{1, 4'h0, 32'hbfaf000C, 32'h0,
                   32'hDEADBEEF, 16'hAB34, 0});
    vt.push_back('{1, 4'h1, 32'hbfaf000C, 32'h000000FF,
                   32'hDEADBEEF, 16'hAB34, 0});
    vt.push_back('{1, 4'h0, 32'hbfaf000F, 32'h0,
                   32'hDEADBEFF, 16'hAB34, 0});
    vt.push_back('{0, 4'h0, 32'hbfaf0020, 32'h0,
                   32'hDEADBEFF, 16'hAB34, 0});
    vt.push_back('{1, 4'hF, 32'hbfaf0014, 32'h12345678,
                   32'hDEADBEFF, 16'hAB34, 1});
    vt.push_back('{1, 4'h0, 32'hbfaf0010, 32'h0,
                   32'h1, 16'hAB34, 1});
    vt.push_back('{1, 4'h2, 32'hbfaf0010, 32'h1,
                   32'h1, 16'hAB34, 1});
    vt.push_back('{1, 4'h1, 32'hbfaf0010, 32'h0,
                   32'h1, 16'hAB34, 1});
    vt.push_back('{1, 4'h1, 32'hbfaf0010, 32'hFFFFFFFF,
                   32'h1, 16'hAB34, 0});
    vt.push_back('{1, 4'hC, 32'hbfaf0000, 32'hFFFF0000,
                   32'h1, 16'hAB34, 0});
    vt.push_back('{1, 4'h0, 32'h12340040, 32'h0,
                   32'h1122AA44, 16'hAB34, 0});
`ifdef DATA_SRAM_TIMER_EN
    vt.push_back('{1, 4'hF, 32'hbfaf0008, 32'h0,
                   32'h1122AA44, 16'hAB34, 0});
`else
    vt.push_back('{1, 4'h0, 32'hbfaf0008, 32'h0,
                   32'h0, 16'hAB34, 1});
    vt.push_back('{1, 4'h1, 32'hbfaf0010, 32'h1,
                   32'h0, 16'hAB34, 0});
`endif

    apply(1, 0, 4'h0, 32'h0, 32'h0, 8'h0);
    apply(1, 1, 4'hF, 32'hbfaf000C, 32'hFFFFFFFF, 8'h0);
    chk3("reset", 32'h0, 16'h0, 0);

    foreach (vt[i]) begin
      apply(0, vt[i].en, vt[i].wen, vt[i].addr, vt[i].wdata, 8'h0);
      chk3($sformatf("vec%0d", i), vt[i].rdata, vt[i].led, vt[i].err);
    end

    // switch synchronizer: visible two cycles after the change
    apply(0, 0, 4'h0, 32'h0, 32'h0, 8'h5A);
    apply(0, 1, 4'h0, 32'hbfaf0004, 32'h0, 8'h5A);
    chk("sw_early", sram_rdata, 32'h0);
    apply(0, 1, 4'h0, 32'hbfaf0004, 32'h0, 8'h5A);
    chk("sw_sync", sram_rdata, 32'h0000005A);

    // reset with a pending scratch write
    apply(0, 1, 4'hF, 32'hbfaf000C, 32'hDEADBEEF, 8'h5A);
    apply(1, 1, 4'hF, 32'hbfaf000C, 32'h12345678, 8'h5A);
    chk3("rst_mid", 32'h0, 16'h0, 0);
    apply(0, 1, 4'h0, 32'hbfaf000C, 32'h0, 8'h5A);
    chk("rst_scr", sram_rdata, 32'h0);
    apply(0, 1, 4'h0, 32'hbfaf0004, 32'h0, 8'h5A);
    chk("rst_sw0", sram_rdata, 32'h0);
    apply(0, 1, 4'h0, 32'hbfaf0004, 32'h0, 8'h5A);
    chk("rst_sw1", sram_rdata, 32'h0000005A);
    apply(0, 1, 4'h0, 32'h00000040, 32'h0, 8'h5A);
    chk("ram_keep", sram_rdata, 32'h1122AA44);

`ifdef DATA_SRAM_TIMER_EN
    apply(0, 1, 4'hF, 32'hbfaf0008, 32'h00000100, 8'h5A);
    repeat (4) apply(0, 0, 4'h0, 32'h0, 32'h0, 8'h5A);
    apply(0, 1, 4'h0, 32'hbfaf0008, 32'h0, 8'h5A);
    chk("tmr_cnt", sram_rdata, 32'h00000104);
    apply(0, 1, 4'hF, 32'hbfaf0008, 32'hFFFFFFFF, 8'h5A);
    apply(0, 0, 4'h0, 32'h0, 32'h0, 8'h5A);
    apply(0, 1, 4'h0, 32'hbfaf0008, 32'h0, 8'h5A);
    chk("tmr_wrap", sram_rdata, 32'h0);
    chk("tmr_err", {31'h0, err_flag}, 32'h0);
`endif

    // random run against the model
    model_step(1, 0, 4'h0, 32'h0, 32'h0, 8'h0);
    apply(1, 0, 4'h0, 32'h0, 32'h0, 8'h0);
    for (int i = 0; i < 16; i++) begin
      wdata = $urandom;
      addr  = {16'h0000, 10'h0, 4'(i), 2'b00};
      model_step(0, 1, 4'hF, addr, wdata, 8'h0);
      apply(0, 1, 4'hF, addr, wdata, 8'h0);
    end
    for (int n = 0; n < 800; n++) begin
      rst   = $urandom_range(0, 63) == 0;
      en    = $urandom_range(0, 3) != 0;
      wen   = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      wdata = $urandom;
      sw    = 8'($urandom);
      if ($urandom_range(0, 1)) begin
        addr = {16'($urandom_range(0, 16'hbfae)), 2'($urandom),
                8'h0, 4'($urandom), 2'($urandom)};
      end else begin
        case ($urandom_range(0, 7))
          0: off = 16'h0;
          1: off = 16'h4;
          2: off = 16'h8;
          3: off = 16'hc;
          4: off = 16'h10;
          5: off = 16'h14;
          6: off = 16'h20;
          default: off = 16'h100;
        endcase
        addr = {16'hbfaf, off | 16'($urandom_range(0, 3))};
      end
      model_step(rst, en, wen, addr, wdata, sw);
      apply(rst, en, wen, addr, wdata, sw);
      chk3($sformatf("rnd%0d", n), m_rdata, m_led, m_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Responder for the CPU data SRAM interface. Accepts the core's `en`/`wen`/`addr`/`wdata` requests and returns `rdata` with fixed one-cycle read latency. Decodes each access into a local byte-writable word RAM or a small MMIO register file: LED, switch, timer, scratch and error status. Sits outside `mycpu_top`, wired to its data SRAM port in the SoC and simulation top levels.

## Interface
- `RAM_AW`, 12: RAM word-address width; depth is 2^RAM_AW words, indexed by `sram_addr[RAM_AW+1:2]`.
- `MMIO_HI`, 16'hbfaf: value of `sram_addr[31:16]` that selects MMIO; any other value selects RAM.

Ports:
- `clk` in 1: sole clock, all logic on posedge.
- `reset` in 1: synchronous, active-high reset.
- `sram_en` in 1: request valid this cycle.
- `sram_wen` in 4: byte write enables; 0 means read, nonzero means write.
- `sram_addr` in 32: byte address; bits [1:0] ignored.
- `sram_wdata` in 32: write data, lane i is bits [8i+7:8i].
- `sram_rdata` out 32: registered read data.
- `led` out 16: LED register.
- `switch` in 8: asynchronous switch inputs.
- `err_flag` out 1: sticky unmapped-MMIO-access flag.

## Operation
- Request on `sram_en`=1 with `wen`=0 (read): `sram_rdata` loads the addressed word at the clock edge, then holds until the next read.
- Request on `sram_en`=1 with `wen`≠0 (write): each enabled lane is merged into the target at the edge. `sram_rdata` is unchanged.
- No request when `sram_en`=0: nothing changes except the timer and the switch synchronizer.
- MMIO register map, by offset `addr[15:0]`:
  - 0x00 LED: RW, bits [15:0]. Lanes 0–1 are writable. Reads return the value zero-extended. Drives `led`.
  - 0x04 SWITCH: RO, the 2-flop-synchronized `switch`, zero-extended. Writes are ignored and do not set the error flag.
  - 0x08 TIMER: RW, 32-bit. Increments by 1 every cycle and wraps from 0xFFFFFFFF to 0. A write merges the enabled lanes into the current value; in that cycle the write replaces the increment. A read returns the value held in the request cycle.
  - 0x0C SCRATCH: RW, 32-bit, byte-lane writes.
  - 0x10 ERR: bit0 = `err_flag`, other bits read 0. Writing with `wen[0]`=1 and `wdata[0]`=1 clears it (W1C). In the same cycle, a new error wins over a clear.
  - Any other offset: reads return 0, writes are dropped, and `err_flag` sets in both cases.
- RAM: single port, no read-during-write case (one request per cycle). Contents are not reset.

## Timing
- Read latency is 1 cycle: a request in cycle t has data on `sram_rdata` in t+1.
- A write is visible to a read issued in the next cycle.
- The CPU can issue back-to-back requests every cycle; there is no stall or backpressure.
- Writes to LED, TIMER and SCRATCH take effect at the edge; `led` changes in the cycle after the write.
- Switch path: a change on `switch` is readable from a request issued at least 2 cycles after the change.
- During reset, and in the cycle after it, these read 0: `sram_rdata`, `led`, timer, scratch, `err_flag` and both synchronizer stages.
- Reset during a request: the request is discarded and no RAM or register write occurs.

## Configuration
- `DATA_SRAM_TIMER_EN` defined: TIMER register and counter are built as described.
- Macro undefined: no counter logic is built. Offset 0x08 is treated as unmapped: reads return 0, writes are dropped, and `err_flag` sets.

## Test plan
- RAM byte write: write 0x11223344 to 0x00000040 with `wen`=F. Then write 0x0000AA00 with `wen`=4'b0010. Then read → 0x1122AA44 in the cycle after the read request.
- LED: write 0xFFFF1234 to 0xbfaf0000 with `wen`=F → `led`=16'h1234 in the next cycle; a read returns 0x00001234.
- Timer: write 0x00000100 to 0xbfaf0008 in cycle t, read in cycle t+5 → 0x00000104. Preload 0xFFFFFFFF and read 2 cycles later → 0x00000000 (wrap).
- Error: read 0xbfaf0020 → `rdata`=0 and `err_flag`=1. Write 0x1 to 0xbfaf0010 → `err_flag`=0 next cycle.
- Reset mid-operation: write 0xDEADBEEF to SCRATCH, hold `reset` for 1 cycle together with a pending SCRATCH write, then read → 0.
- Switch: set `switch`=8'h5A, read 0xbfaf0004 two cycles later → 0x0000005A. With the macro undefined, a read of 0x08 → 0 and sets `err_flag`.
